// File: rtl/address_calculator_arbiter.sv
// Arbitrates the shared address calculator between the load (port 0) and store (port 1)
// reservation stations: oldest-first by ROB age, starvation override, round-robin ties.
module address_calculator_arbiter #(
    parameter int unsigned XLEN            = 64,
    parameter int unsigned ROB_INDEX_WIDTH = 8,
    parameter int unsigned MAX_WAIT        = 8
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    input  logic [ROB_INDEX_WIDTH-1:0] rob_head_i,

    input  logic                       ld_valid_i,
    output logic                       ld_ready_o,
    input  logic [XLEN-1:0]            ld_1st_reg_i,
    input  logic [XLEN-1:0]            ld_2nd_reg_i,
    input  logic [XLEN-1:0]            ld_address_i,
    input  logic [ROB_INDEX_WIDTH-1:0] ld_rob_index_i,

    input  logic                       st_valid_i,
    output logic                       st_ready_o,
    input  logic [XLEN-1:0]            st_1st_reg_i,
    input  logic [XLEN-1:0]            st_2nd_reg_i,
    input  logic [XLEN-1:0]            st_address_i,
    input  logic [ROB_INDEX_WIDTH-1:0] st_rob_index_i,

    output logic                       dispatch_valid_o,
    input  logic                       dispatch_ready_i,
    output logic [XLEN-1:0]            dispatch_1st_reg_o,
    output logic [XLEN-1:0]            dispatch_2nd_reg_o,
    output logic [XLEN-1:0]            dispatch_address_o,
    output logic [ROB_INDEX_WIDTH-1:0] dispatch_rob_index_o,
    output logic                       grant_id_o
);

    localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

    logic             lock_q, lock_d;
    logic             lock_id_q, lock_id_d;
    logic             last_grant_q, last_grant_d;
    logic [WaitW-1:0] wait_ld_q, wait_ld_d;
    logic [WaitW-1:0] wait_st_q, wait_st_d;

    logic                       sel;
    logic                       fire;
    logic                       clear;
    logic                       sat_ld, sat_st;
    logic [ROB_INDEX_WIDTH-1:0] ld_age, st_age;

    assign clear  = reset_i | flush_i;
    // Subtraction wraps modulo 2^ROB_INDEX_WIDTH, giving distance from the ROB head.
    assign ld_age = ld_rob_index_i - rob_head_i;
    assign st_age = st_rob_index_i - rob_head_i;
    assign sat_ld = (wait_ld_q == WaitMax);
    assign sat_st = (wait_st_q == WaitMax);

    always_comb begin
        sel = ~last_grant_q;
        if (lock_q) begin
            sel = lock_id_q;
        end else if (ld_valid_i && !st_valid_i) begin
            sel = 1'b0;
        end else if (st_valid_i && !ld_valid_i) begin
            sel = 1'b1;
        end else if (sat_ld != sat_st) begin
            sel = sat_st;
        end else if (sat_ld && sat_st) begin
            sel = ~last_grant_q;
        end else if (ld_age < st_age) begin
            sel = 1'b0;
        end else if (st_age < ld_age) begin
            sel = 1'b1;
        end
    end

    assign dispatch_valid_o     = (ld_valid_i | st_valid_i) & ~clear;
    assign dispatch_1st_reg_o   = sel ? st_1st_reg_i : ld_1st_reg_i;
    assign dispatch_2nd_reg_o   = sel ? st_2nd_reg_i : ld_2nd_reg_i;
    assign dispatch_address_o   = sel ? st_address_i : ld_address_i;
    assign dispatch_rob_index_o = sel ? st_rob_index_i : ld_rob_index_i;
    assign grant_id_o           = sel;
    assign ld_ready_o           = dispatch_ready_i & ~sel & dispatch_valid_o;
    assign st_ready_o           = dispatch_ready_i & sel & dispatch_valid_o;
    assign fire                 = dispatch_valid_o & dispatch_ready_i;

    always_comb begin
        lock_d       = lock_q;
        lock_id_d    = lock_id_q;
        last_grant_d = last_grant_q;
        if (fire) begin
            lock_d       = 1'b0;
            last_grant_d = sel;
        end else if (dispatch_valid_o) begin
            lock_d    = 1'b1;
            lock_id_d = sel;
        end

        if (fire && !sel) begin
            wait_ld_d = '0;
        end else if (ld_valid_i) begin
            wait_ld_d = sat_ld ? wait_ld_q : wait_ld_q + 1'b1;
        end else begin
            wait_ld_d = '0;
        end

        if (fire && sel) begin
            wait_st_d = '0;
        end else if (st_valid_i) begin
            wait_st_d = sat_st ? wait_st_q : wait_st_q + 1'b1;
        end else begin
            wait_st_d = '0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (clear) begin
            lock_q       <= 1'b0;
            lock_id_q    <= 1'b0;
            last_grant_q <= 1'b1;
            wait_ld_q    <= '0;
            wait_st_q    <= '0;
        end else begin
            lock_q       <= lock_d;
            lock_id_q    <= lock_id_d;
            last_grant_q <= last_grant_d;
            wait_ld_q    <= wait_ld_d;
            wait_st_q    <= wait_st_d;
        end
    end

endmodule

// File: tb/tb_address_calculator_arbiter.sv
// Directed bench for address_calculator_arbiter: age ordering, wrap, locking, starvation, flush.
module tb_address_calculator_arbiter;

    localparam int unsigned XLEN = 64;
    localparam int unsigned RW   = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            flush = 1'b0;
    logic [RW-1:0]   rob_head = '0;
    logic            ld_valid = 1'b0, st_valid = 1'b0;
    logic            ld_ready, st_ready;
    logic [XLEN-1:0] ld_1st = 64'h1111_0000_0000_0001, ld_2nd = 64'h1111_0000_0000_0002;
    logic [XLEN-1:0] ld_addr = 64'h1111_0000_0000_0003;
    logic [XLEN-1:0] st_1st = 64'h2222_0000_0000_0001, st_2nd = 64'h2222_0000_0000_0002;
    logic [XLEN-1:0] st_addr = 64'h2222_0000_0000_0003;
    logic [RW-1:0]   ld_idx = '0, st_idx = '0;
    logic            d_valid, d_ready = 1'b0;
    logic [XLEN-1:0] d_1st, d_2nd, d_addr;
    logic [RW-1:0]   d_idx;
    logic            grant;

    integer tests_run = 0;
    integer failures  = 0;

    always #5 clock = ~clock;

    address_calculator_arbiter #(
        .XLEN            (XLEN),
        .ROB_INDEX_WIDTH (RW),
        .MAX_WAIT        (4)
    ) dut (
        .clock_i              (clock),
        .reset_i              (reset),
        .flush_i              (flush),
        .rob_head_i           (rob_head),
        .ld_valid_i           (ld_valid),
        .ld_ready_o           (ld_ready),
        .ld_1st_reg_i         (ld_1st),
        .ld_2nd_reg_i         (ld_2nd),
        .ld_address_i         (ld_addr),
        .ld_rob_index_i       (ld_idx),
        .st_valid_i           (st_valid),
        .st_ready_o           (st_ready),
        .st_1st_reg_i         (st_1st),
        .st_2nd_reg_i         (st_2nd),
        .st_address_i         (st_addr),
        .st_rob_index_i       (st_idx),
        .dispatch_valid_o     (d_valid),
        .dispatch_ready_i     (d_ready),
        .dispatch_1st_reg_o   (d_1st),
        .dispatch_2nd_reg_o   (d_2nd),
        .dispatch_address_o   (d_addr),
        .dispatch_rob_index_o (d_idx),
        .grant_id_o           (grant)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        ld_valid = 1'b0;
        st_valid = 1'b0;
        d_ready  = 1'b0;
        flush    = 1'b0;
        reset    = 1'b1;
        step();
        reset    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ld_valid = 1'b1; st_valid = 1'b1; d_ready = 1'b1;
        ld_idx = 8'd7; st_idx = 8'd7; rob_head = 8'd0;
        #1;
        tests_run++;
        if ({d_valid, ld_ready, st_ready} !== 3'b000) begin
            failures++;
            $display("FAIL reset_outputs: got v/lr/sr=%b required 000", {d_valid, ld_ready, st_ready});
        end
        step();
        reset = 1'b0;
        #1;
        tests_run++;
        if (grant !== 1'b0 || ld_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_tie: got grant=%b ld_ready=%b required 0 1", grant, ld_ready);
        end
        step();
        #1;
        tests_run++;
        if (grant !== 1'b1 || st_ready !== 1'b1) begin
            failures++;
            $display("FAIL tie_round_robin: got grant=%b st_ready=%b required 1 1", grant, st_ready);
        end
        ld_valid = 1'b0; st_valid = 1'b0;
        step();
    endtask

    task automatic test_load_only();
        do_reset();
        rob_head = 8'd0; ld_idx = 8'd5; ld_valid = 1'b1; d_ready = 1'b1;
        #1;
        tests_run++;
        if ({d_valid, grant, ld_ready, st_ready} !== 4'b1010) begin
            failures++;
            $display("FAIL load_only: got v/g/lr/sr=%b required 1010",
                     {d_valid, grant, ld_ready, st_ready});
        end
        tests_run++;
        if (d_1st !== ld_1st || d_2nd !== ld_2nd || d_addr !== ld_addr || d_idx !== 8'd5) begin
            failures++;
            $display("FAIL load_payload: got %h %h %h %h required %h %h %h 05",
                     d_1st, d_2nd, d_addr, d_idx, ld_1st, ld_2nd, ld_addr);
        end
        step();
    endtask

    task automatic test_age_order();
        do_reset();
        rob_head = 8'd240; ld_idx = 8'd250; st_idx = 8'd3;
        ld_valid = 1'b1; st_valid = 1'b1; d_ready = 1'b1;
        #1;
        tests_run++;
        if ({grant, ld_ready, st_ready} !== 3'b010) begin
            failures++;
            $display("FAIL age_load_older: got g/lr/sr=%b required 010", {grant, ld_ready, st_ready});
        end
        step();
        do_reset();
        rob_head = 8'd250; ld_idx = 8'd2; st_idx = 8'd252;
        ld_valid = 1'b1; st_valid = 1'b1; d_ready = 1'b1;
        #1;
        tests_run++;
        if ({grant, ld_ready, st_ready} !== 3'b101) begin
            failures++;
            $display("FAIL age_wrap_store: got g/lr/sr=%b required 101", {grant, ld_ready, st_ready});
        end
        tests_run++;
        if (d_addr !== st_addr || d_idx !== 8'd252) begin
            failures++;
            $display("FAIL store_payload: got addr=%h idx=%0d required %h 252", d_addr, d_idx, st_addr);
        end
        step();
    endtask

    task automatic test_lock();
        do_reset();
        rob_head = 8'd0; st_idx = 8'd20; ld_idx = 8'd10;
        st_valid = 1'b1; d_ready = 1'b0;
        #1;
        tests_run++;
        if (d_valid !== 1'b1 || grant !== 1'b1 || st_ready !== 1'b0) begin
            failures++;
            $display("FAIL lock_start: got v=%b g=%b sr=%b required 1 1 0", d_valid, grant, st_ready);
        end
        step();
        ld_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            tests_run++;
            if (grant !== 1'b1 || d_idx !== 8'd20 || ld_ready !== 1'b0) begin
                failures++;
                $display("FAIL lock_hold[%0d]: got g=%b idx=%0d lr=%b required 1 20 0",
                         c, grant, d_idx, ld_ready);
            end
            step();
        end
        d_ready = 1'b1;
        #1;
        tests_run++;
        if ({grant, ld_ready, st_ready} !== 3'b101) begin
            failures++;
            $display("FAIL lock_release: got g/lr/sr=%b required 101", {grant, ld_ready, st_ready});
        end
        step();
        st_valid = 1'b0;
        #1;
        tests_run++;
        if ({d_valid, grant, ld_ready} !== 3'b101) begin
            failures++;
            $display("FAIL lock_next_load: got v/g/lr=%b required 101", {d_valid, grant, ld_ready});
        end
        step();
        ld_valid = 1'b0;
    endtask

    task automatic test_starvation();
        do_reset();
        rob_head = 8'd0; st_idx = 8'd100; st_valid = 1'b1; ld_valid = 1'b1; d_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            ld_idx = 8'(10 + c);
            #1;
            tests_run++;
            if (c < 4 && (grant !== 1'b0 || ld_ready !== 1'b1)) begin
                failures++;
                $display("FAIL starve_lose[%0d]: got g=%b lr=%b required 0 1", c, grant, ld_ready);
            end else if (c == 4 && (grant !== 1'b1 || st_ready !== 1'b1 || ld_ready !== 1'b0)) begin
                failures++;
                $display("FAIL starve_force: got g=%b sr=%b lr=%b required 1 1 0",
                         grant, st_ready, ld_ready);
            end
            step();
        end
        st_valid = 1'b0; ld_valid = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        rob_head = 8'd0; st_idx = 8'd30; ld_idx = 8'd30;
        st_valid = 1'b1; d_ready = 1'b0;
        step();
        ld_valid = 1'b1; flush = 1'b1; d_ready = 1'b1;
        #1;
        tests_run++;
        if ({d_valid, ld_ready, st_ready} !== 3'b000) begin
            failures++;
            $display("FAIL flush_outputs: got v/lr/sr=%b required 000", {d_valid, ld_ready, st_ready});
        end
        step();
        flush = 1'b0;
        #1;
        tests_run++;
        if ({d_valid, grant, ld_ready, st_ready} !== 4'b1010) begin
            failures++;
            $display("FAIL flush_unlock_tie: got v/g/lr/sr=%b required 1010",
                     {d_valid, grant, ld_ready, st_ready});
        end
        step();
        ld_valid = 1'b0; st_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_only();
        test_age_order();
        test_lock();
        test_starvation();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
